fetch_stage: RTL

//  Instruction fetch stage with PC register, instruction-memory req/ready handshake, and IF/ID register.

---
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem req/ready handshake, IF/ID register
// with a one-entry skid buffer, redirect and flush handling.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating perf counters
// perf_stall_cyc and perf_drop_cnt.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no request on the bus; issue at pc when IF/ID can take data
// REQ   | request at pc outstanding, waiting for imem_ready
// HOLD  | response parked in skid while decode stalls, no new request
// DROP  | wrong-path request outstanding after redirect, data discarded
//
// A redirect during DROP without imem_ready stays in DROP, so the bus
// handshake is never abandoned while a request is still outstanding.
module fetch_stage #(
   parameter int                  PC_WIDTH    = 64,
   parameter int                  INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ready,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_pc,
   input  logic [PC_WIDTH-1:0]    branch_offset,
   output logic                   if_id_valid,
   output logic [PC_WIDTH-1:0]    if_id_pc,
   output logic [INSTR_WIDTH-1:0] if_id_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            perf_stall_cyc,
   output logic [31:0]            perf_drop_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic                   req_q, req_d;
   logic [PC_WIDTH-1:0]    addr_q, addr_d;
   logic                   iv_q, iv_d;
   logic [PC_WIDTH-1:0]    ipc_q, ipc_d;
   logic [INSTR_WIDTH-1:0] iin_q, iin_d;
   logic [PC_WIDTH-1:0]    spc_q, spc_d;
   logic [INSTR_WIDTH-1:0] sin_q, sin_d;
   logic                   blocked;
   logic [PC_WIDTH-1:0]    target;

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign if_id_valid = iv_q;
   assign if_id_pc    = ipc_q;
   assign if_id_instr = iin_q;

   // Next-state logic; flush empties IF/ID at the start of the cycle, so a
   // response in the same cycle may load regardless of stall.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      iv_d    = iv_q;
      ipc_d   = ipc_q;
      iin_d   = iin_q;
      spc_d   = spc_q;
      sin_d   = sin_q;
      blocked = iv_q && !flush && stall;
      target  = branch_pc + (branch_offset << 2);
      if (branch_taken) begin
         pc_d    = target;
         iv_d    = 1'b0;
         state_d = (req_q && !imem_ready) ? S_DROP : S_IDLE;
      end else begin
         if (flush) iv_d = 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (!blocked) begin
                  state_d = S_REQ;
                  addr_d  = pc_q;
               end
            end
            S_REQ: begin
               if (imem_ready) begin
                  pc_d = pc_q + PC_STEP;
                  if (!blocked) begin
                     iv_d    = 1'b1;
                     ipc_d   = pc_q;
                     iin_d   = imem_rdata;
                     state_d = S_IDLE;
                  end else begin
                     spc_d   = pc_q;
                     sin_d   = imem_rdata;
                     state_d = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (flush) begin
                  state_d = S_IDLE;
               end else if (!stall) begin
                  iv_d    = 1'b1;
                  ipc_d   = spc_q;
                  iin_d   = sin_q;
                  state_d = S_IDLE;
               end
            end
            S_DROP: begin
               if (imem_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      req_d = (state_d == S_REQ) || (state_d == S_DROP);
   end

   // State, PC, bus and pipeline registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= '0;
         iv_q    <= 1'b0;
         ipc_q   <= '0;
         iin_q   <= '0;
         spc_q   <= '0;
         sin_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         iv_q    <= iv_d;
         ipc_q   <= ipc_d;
         iin_q   <= iin_d;
         spc_q   <= spc_d;
         sin_q   <= sin_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cyc_q, stall_cyc_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic        dropped;

   assign perf_stall_cyc = stall_cyc_q;
   assign perf_drop_cnt  = drop_cnt_q;

   // Saturating counters for stalled-valid cycles and discarded responses
   always_comb begin
      stall_cyc_d = stall_cyc_q;
      drop_cnt_d  = drop_cnt_q;
      dropped     = imem_ready && ((state_q == S_DROP) ||
                                   ((state_q == S_REQ) && branch_taken));
      if (stall && iv_q && (stall_cyc_q != 32'hFFFF_FFFF))
         stall_cyc_d = stall_cyc_q + 32'd1;
      if (dropped && (drop_cnt_q != 32'hFFFF_FFFF))
         drop_cnt_d = drop_cnt_q + 32'd1;
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cyc_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         stall_cyc_q <= stall_cyc_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end
`endif

endmodule
